// File: rtl/shift_result_stage.sv
// Registered result stage behind the 32-bit barrel shifter: flags + 2-entry skid buffer.
// Optional accepted-result counter enabled by defining SHIFT_RESULT_STATS_EN.
module shift_result_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [31:0] in_a,
  input  logic [4:0]  in_shamt,
  input  logic        in_ctl0,
  input  logic        in_ctl1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_neg,
  output logic        out_carry,
  output logic [15:0] stat_count
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("shift_result_stage only supports DEPTH == 2");
  end

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        carry;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  entry_t head_q, skid_q, new_entry;
  logic   push, pop;
  logic [5:0] carry_idx;
  logic   new_carry;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Carry is the last bit of A shifted out; arithmetic vs logical makes no difference here.
  always_comb begin
    carry_idx = 6'd0;
    new_carry = 1'b0;
    if (in_shamt != 5'd0) begin
      if (in_ctl1) carry_idx = 6'd32 - {1'b0, in_shamt};
      else         carry_idx = {1'b0, in_shamt} - 6'd1;
      new_carry = in_a[carry_idx[4:0]];
    end
  end

  assign new_entry = '{result: in_result, zero: (in_result == 32'd0), neg: in_result[31],
                       carry: new_carry};

  logic unused_in;
  assign unused_in = ^{in_ctl0, carry_idx[5]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (push) state_d = StOne;
      StOne: begin
        if (push && !pop)      state_d = StTwo;
        else if (pop && !push) state_d = StEmpty;
      end
      StTwo:   if (pop) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      head_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d != StEmpty);
      in_ready  <= (state_d != StTwo);
      unique case (state_q)
        StEmpty: if (push) head_q <= new_entry;
        StOne: begin
          if (push && pop) head_q <= new_entry;
          else if (push)   skid_q <= new_entry;
        end
        StTwo:   if (pop) head_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_result = head_q.result;
  assign out_zero   = head_q.zero;
  assign out_neg    = head_q.neg;
  assign out_carry  = head_q.carry;

`ifdef SHIFT_RESULT_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else if (push && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign stat_count = count_q;
`else
  assign stat_count = 16'd0;
`endif

endmodule

// File: tb/tb_shift_result_stage.sv
// Self-checking bench for shift_result_stage against a queue-based reference model.
module tb_shift_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_result, in_a;
  logic [4:0]  in_shamt;
  logic        in_ctl0, in_ctl1;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_neg, out_carry;
  logic [15:0] stat_count;

  int total = 0;
  int bad   = 0;

  logic [34:0] q[$];
  int unsigned m_stat;

  logic [36:0] obs_vec;
  assign obs_vec = {out_valid, in_ready, out_result, out_zero, out_neg, out_carry};

  shift_result_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_a(in_a),
    .in_shamt(in_shamt), .in_ctl0(in_ctl0), .in_ctl1(in_ctl1),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  // Flags from first principles: shift a 33-bit widened A and look at the bit pushed off the end.
  function automatic logic [34:0] model_entry(input logic [31:0] a, input logic [4:0] sh,
                                              input logic left, input logic [31:0] res);
    logic [32:0] ext;
    logic c;
    if (left) begin
      ext = {1'b0, a} << sh;
      c = ext[32];
    end else begin
      ext = {a, 1'b0} >> sh;
      c = ext[0];
    end
    return {res, (res == 32'd0), res[31], c};
  endfunction

  function automatic logic [36:0] exp_vec();
    if (q.size() == 0) return {1'b0, 1'b1, 35'd0};
    return {1'b1, (q.size() < 2), q[0]};
  endfunction

  // Head fields are unspecified while empty; only valid/ready are compared then.
  function automatic logic [36:0] exp_mask();
    if (q.size() == 0) return 37'h18_0000_0000;
    return '1;
  endfunction

  function automatic logic [15:0] exp_stat();
`ifdef SHIFT_RESULT_STATS_EN
    return m_stat[15:0];
`else
    return 16'd0;
`endif
  endfunction

  task automatic tick();
    logic push_m, pop_m;
    logic [34:0] e;
    @(posedge clk);
    if (rst_n) begin
      push_m = in_valid && (q.size() < 2);
      pop_m  = (q.size() > 0) && out_ready;
      e = model_entry(in_a, in_shamt, in_ctl1, in_result);
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(e);
        if (m_stat != 32'hFFFF) m_stat++;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    in_a      = $urandom;
    in_shamt  = 5'($urandom_range(0, 31));
    in_ctl0   = 1'($urandom_range(0, 1));
    in_ctl1   = 1'($urandom_range(0, 1));
    in_result = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_shamt = '0; in_ctl0 = 1'b0; in_ctl1 = 1'b0; in_result = '0;
    q.delete();
    m_stat = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs_vec !== {1'b0, 1'b1, 32'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs_vec, {1'b0, 1'b1, 32'd0, 3'b000});
    end
    total++;
    if (stat_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_stat: got %h want 0000", stat_count);
    end
  endtask

  task automatic test_flags();
    logic [31:0] ca[4] = '{32'h0000_0001, 32'h8000_0003, 32'h8000_0003, 32'h8000_0000};
    logic [4:0]  cs[4] = '{5'd1, 5'd2, 5'd0, 5'd1};
    logic        c0[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        c1[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] cr[4] = '{32'h0000_0002, 32'hE000_0000, 32'h8000_0003, 32'h0000_0000};
    logic [2:0]  cf[4] = '{3'b000, 3'b011, 3'b010, 3'b101};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a = ca[i]; in_shamt = cs[i]; in_ctl0 = c0[i]; in_ctl1 = c1[i]; in_result = cr[i];
      tick();
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_result, out_zero, out_neg, out_carry} !== {1'b1, cr[i], cf[i]}) begin
        bad++;
        $display("FAIL flags_case%0d: got v=%b r=%h zнc=%b want v=1 r=%h znc=%b", i, out_valid,
                 out_result, {out_zero, out_neg, out_carry}, cr[i], cf[i]);
      end
      total++;
      if ((obs_vec & exp_mask()) !== exp_vec()) begin
        bad++;
        $display("FAIL flags_model%0d: got %h want %h", i, obs_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [36:0] first_head;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
      total++;
      if ((obs_vec & exp_mask()) !== exp_vec() || in_ready !== (i == 0)) begin
        bad++;
        $display("FAIL stall_push%0d: got %h want %h", i, obs_vec, exp_vec());
      end
      if (i == 0) first_head = obs_vec;
    end
    total++;
    if (q.size() != 2 || obs_vec[34:0] !== first_head[34:0]) begin
      bad++;
      $display("FAIL stall_hold: got %h want %h (model depth %0d)", obs_vec[34:0],
               first_head[34:0], q.size());
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ((obs_vec & exp_mask()) !== exp_vec()) begin
        bad++;
        $display("FAIL stall_drain%0d: got %h want %h", i, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want_stat;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      tick();
      total++;
      if ((obs_vec & exp_mask()) !== exp_vec() || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream%0d: got %h want %h", i, obs_vec, exp_vec());
      end
    end
    in_valid = 1'b0;
    tick();
`ifdef SHIFT_RESULT_STATS_EN
    want_stat = 16'd20;
`else
    want_stat = 16'd0;
`endif
    total++;
    if (stat_count !== want_stat || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_stat: got cnt=%0d v=%b want cnt=%0d v=0", stat_count, out_valid,
               want_stat);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin
      rand_inputs();
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL arst_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    q.delete();
    m_stat = 0;
    #1;
    total++;
    if ({out_valid, in_ready, out_result} !== {1'b0, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL arst_immediate: got v=%b rdy=%b r=%h want v=0 rdy=1 r=0", out_valid,
               in_ready, out_result);
    end
    in_valid = 1'b1;
    in_a = 32'h8000_0003; in_shamt = 5'd2; in_ctl0 = 1'b1; in_ctl1 = 1'b0;
    in_result = 32'hE000_0000;
    tick();
    total++;
    if (out_valid !== 1'b0 || stat_count !== 16'd0) begin
      bad++;
      $display("FAIL arst_push_ignored: got v=%b cnt=%0d want v=0 cnt=0", out_valid, stat_count);
    end
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_result, out_zero, out_neg, out_carry} !==
        {1'b1, 32'hE000_0000, 3'b011}) begin
      bad++;
      $display("FAIL arst_first_push: got v=%b r=%h znc=%b want v=1 r=e0000000 znc=011",
               out_valid, out_result, {out_zero, out_neg, out_carry});
    end
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rand_inputs();
      tick();
      total++;
      if ((obs_vec & exp_mask()) !== exp_vec() || stat_count !== exp_stat()) begin
        bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL random%0d: got %h cnt=%0d want %h cnt=%0d", i, obs_vec, stat_count,
                   exp_vec(), exp_stat());
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    total++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      bad++;
      $display("FAIL random_drain: got v=%b want v=0 (model depth %0d)", out_valid, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
